// File: rtl/pc_gen.sv
// Fetch-address generator: registered fetch PC with sequential advance and
// prioritised redirects (flush, jump, return-address-stack pop).
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              STEP      = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            rdy_in,
    input  logic            flush_vld,
    input  logic [XLEN-1:0] flush_tar,
    input  logic            jmp_tak,
    input  logic [XLEN-1:0] jmp_tar,
    input  logic            call_vld,
    input  logic [XLEN-1:0] call_pc,
    input  logic            ret_vld,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            ras_miss
);

    localparam int              SPW    = $clog2(RAS_DEPTH);
    localparam int              CW     = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN  = ~(STEP_V - XLEN'(1));
    localparam logic [CW-1:0]   CNT_MAX = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [SPW-1:0]  sp;
    logic [CW-1:0]   cnt;

    logic            live;
    logic            pop;
    logic            push;
    logic            miss;
    logic [SPW-1:0]  top_idx;
    logic [SPW-1:0]  wr_idx;
    logic [XLEN-1:0] ret_tar;
    logic [XLEN-1:0] pc_nxt;

    // Call/ret decode is younger than a flush or jump and is squashed by either.
    assign live    = !flush_vld && !jmp_tak;
    assign pop     = live && ret_vld && (cnt != '0);
    assign miss    = live && ret_vld && (cnt == '0);
    assign push    = live && call_vld;
    assign top_idx = sp - SPW'(1);
    assign wr_idx  = pop ? top_idx : sp;
    assign ret_tar = ras[top_idx] & ALIGN;

    // Handshake: pc_out is offered while pc_valid=1; it is consumed on an edge
    // where pc_ready=1, and only then does the PC advance sequentially.
    // Redirects override the handshake and discard any un-accepted PC.
    always_comb begin
        pc_nxt = pc_out;
        if (flush_vld) begin
            pc_nxt = flush_tar & ALIGN;
        end else if (jmp_tak) begin
            pc_nxt = jmp_tar & ALIGN;
        end else if (pop) begin
            pc_nxt = ret_tar;
        end else if (pc_valid && pc_ready) begin
            pc_nxt = pc_out + STEP_V;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_out   <= RESET_PC;
            pc_valid <= 1'b0;
            ras_miss <= 1'b0;
            sp       <= '0;
            cnt      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (rdy_in) begin
            pc_out   <= pc_nxt;
            pc_valid <= 1'b1;
            ras_miss <= miss;
            if (flush_vld) begin
                sp  <= '0;
                cnt <= '0;
            end else begin
                if (push) begin
                    ras[wr_idx] <= call_pc + STEP_V;
                end
                // Push-and-pop together reuses the popped slot: sp/cnt net unchanged.
                if (push && !pop) begin
                    sp  <= sp + SPW'(1);
                    cnt <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
                end else if (pop && !push) begin
                    sp  <= top_idx;
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: handshake advance, redirect priority, alignment,
// wrap, RAS push/pop/overflow/miss, rdy_in freeze and asynchronous reset.
module tb_pc_gen;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_vld;
    logic [31:0] flush_tar;
    logic        jmp_tak;
    logic [31:0] jmp_tar;
    logic        call_vld;
    logic [31:0] call_pc;
    logic        ret_vld;
    logic        pc_ready;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        ras_miss;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen #(
        .XLEN(32), .RESET_PC(32'h100), .STEP(4), .RAS_DEPTH(4)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .flush_vld(flush_vld), .flush_tar(flush_tar),
        .jmp_tak(jmp_tak), .jmp_tar(jmp_tar),
        .call_vld(call_vld), .call_pc(call_pc), .ret_vld(ret_vld),
        .pc_ready(pc_ready), .pc_out(pc_out), .pc_valid(pc_valid),
        .ras_miss(ras_miss)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr();
        flush_vld = 1'b0; flush_tar = '0;
        jmp_tak   = 1'b0; jmp_tar   = '0;
        call_vld  = 1'b0; call_pc   = '0;
        ret_vld   = 1'b0;
    endtask

    task automatic do_call(input logic [31:0] pc);
        clr();
        call_vld = 1'b1; call_pc = pc;
        tick();
    endtask

    task automatic do_ret(input string tag, input logic [31:0] exp_pc, input logic exp_miss);
        clr();
        ret_vld = 1'b1;
        tick();
        check({tag, "_pc"}, pc_out, exp_pc);
        check({tag, "_miss"}, {31'b0, ras_miss}, {31'b0, exp_miss});
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b0; pc_ready = 1'b0;
        clr();
        tick(); tick();
        check("rst_pc", pc_out, 32'h100);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_miss", {31'b0, ras_miss}, 32'd0);

        rst_n_in = 1'b1;
        tick();
        check("rdy0_valid", {31'b0, pc_valid}, 32'd0);

        // Sequential advance with fetch always ready
        rdy_in = 1'b1; pc_ready = 1'b1;
        tick();
        check("seq_valid", {31'b0, pc_valid}, 32'd1);
        check("seq0", pc_out, 32'h100);
        tick(); check("seq1", pc_out, 32'h104);
        tick(); check("seq2", pc_out, 32'h108);
        pc_ready = 1'b0;
        tick(); check("hold", pc_out, 32'h108);

        // Flush beats jump and ret; the call alongside is discarded
        flush_vld = 1'b1; flush_tar = 32'h2000;
        jmp_tak = 1'b1; jmp_tar = 32'h3000;
        ret_vld = 1'b1; call_vld = 1'b1; call_pc = 32'h500;
        tick();
        check("flush_pc", pc_out, 32'h2000);
        check("flush_miss", {31'b0, ras_miss}, 32'd0);
        do_ret("flush_empty", 32'h2000, 1'b1);

        // rdy_in low freezes everything, including the miss pulse
        rdy_in = 1'b0; clr(); flush_vld = 1'b1; flush_tar = 32'h9000;
        tick();
        check("frz_pc", pc_out, 32'h2000);
        check("frz_miss", {31'b0, ras_miss}, 32'd1);
        rdy_in = 1'b1; clr();
        tick();
        check("miss_drop", {31'b0, ras_miss}, 32'd0);

        flush_vld = 1'b1; flush_tar = 32'h2007;
        tick(); check("flush_align", pc_out, 32'h2004);

        // Jump alignment; call/ret under a jump are squashed
        clr(); jmp_tak = 1'b1; jmp_tar = 32'h3003;
        ret_vld = 1'b1; call_vld = 1'b1; call_pc = 32'h700;
        tick();
        check("jmp_align", pc_out, 32'h3000);
        check("jmp_miss", {31'b0, ras_miss}, 32'd0);
        do_ret("jmp_squash", 32'h3000, 1'b1);

        // Wraparound of the sequential increment
        clr(); jmp_tak = 1'b1; jmp_tar = 32'hFFFF_FFFC;
        tick(); check("wrap_pre", pc_out, 32'hFFFF_FFFC);
        clr(); pc_ready = 1'b1;
        tick(); check("wrap", pc_out, 32'h0);
        pc_ready = 1'b0;

        // Three calls, three returns, then a miss with sequential advance
        do_call(32'h10); check("call_nored", pc_out, 32'h0);
        do_call(32'h20);
        do_call(32'h30);
        do_ret("r1", 32'h34, 1'b0);
        do_ret("r2", 32'h24, 1'b0);
        do_ret("r3", 32'h14, 1'b0);
        pc_ready = 1'b1;
        do_ret("r4", 32'h18, 1'b1);
        clr(); pc_ready = 1'b0;
        tick();
        check("r4_pulse", {31'b0, ras_miss}, 32'd0);
        check("r4_hold", pc_out, 32'h18);

        // Overflow: fifth push overwrites the oldest entry
        for (int i = 1; i <= 5; i++) do_call(32'(i * 16));
        do_ret("o1", 32'h54, 1'b0);
        do_ret("o2", 32'h44, 1'b0);
        do_ret("o3", 32'h34, 1'b0);
        do_ret("o4", 32'h24, 1'b0);
        do_ret("o5", 32'h24, 1'b1);

        // Simultaneous push and pop
        do_call(32'h10);
        do_call(32'h20);
        clr(); call_vld = 1'b1; call_pc = 32'h40; ret_vld = 1'b1;
        tick(); check("pp_pc", pc_out, 32'h24);
        do_ret("pp_top", 32'h44, 1'b0);
        do_ret("pp_next", 32'h14, 1'b0);
        do_ret("pp_empty", 32'h14, 1'b1);

        // Push alongside a miss still lands
        clr(); tick();
        clr(); call_vld = 1'b1; call_pc = 32'h60; ret_vld = 1'b1;
        tick(); check("mp_miss", {31'b0, ras_miss}, 32'd1);
        do_ret("mp_pop", 32'h64, 1'b0);

        // Asynchronous reset mid-stream, with a non-empty RAS
        do_call(32'h80);
        #3 rst_n_in = 1'b0;
        #1;
        check("arst_pc", pc_out, 32'h100);
        check("arst_valid", {31'b0, pc_valid}, 32'd0);
        check("arst_miss", {31'b0, ras_miss}, 32'd0);
        #2 rst_n_in = 1'b1;
        clr(); ret_vld = 1'b1;
        tick();
        check("post_valid", {31'b0, pc_valid}, 32'd1);
        check("post_pc", pc_out, 32'h100);
        check("post_miss", {31'b0, ras_miss}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
